// File: rtl/aes_job_ctrl_pkg.sv
// Shared types for the AES job controller: cipher modes, controller states and the queued job record.
package aes_package;

  localparam int JOB_CNT_MAX  = 32;
  localparam int JOB_CORE_MAX = 8;

  typedef enum logic [1:0] {
    AES_ECB_ENC = 2'b00,
    AES_ECB_DEC = 2'b01,
    AES_CBC_ENC = 2'b10,
    AES_CBC_DEC = 2'b11
  } aes_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } ctrl_state_t;

  // Fields are sized for the widest supported build; the controller narrows them on use.
  typedef struct packed {
    logic [JOB_CNT_MAX-1:0]  nb_blocks;
    aes_mode_t               mode;
    logic [JOB_CORE_MAX-1:0] core;
  } job_t;

  function automatic logic is_cbc(input aes_mode_t mode);
    return (mode == AES_CBC_ENC) || (mode == AES_CBC_DEC);
  endfunction

endpackage

// File: rtl/aes_job_ctrl_fifo.sv
// Job queue for the AES controller: DEPTH entries (power of two), synchronous clear wins over push/pop.
module aes_job_fifo
  import aes_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  job_t                     push_data,
  input  logic                     pop,
  output job_t                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/aes_job_ctrl.sv
// AES job controller: queues jobs and sequences load/engine/store per block, raising a per-core event.
// Optional engine watchdog enabled by defining AES_JOB_CTRL_TIMEOUT_EN.
module aes_job_ctrl
  import aes_package::*;
#(
  parameter  int N_CORES     = 2,
  parameter  int JOB_DEPTH   = 4,
  parameter  int CNT_W       = 16,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int CORE_W      = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int PEND_W      = $clog2(JOB_DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               job_valid_i,
  output logic               job_ready_o,
  input  logic [CNT_W-1:0]   job_nb_blocks_i,
  input  aes_mode_t          job_mode_i,
  input  logic [CORE_W-1:0]  job_core_i,
  output logic               load_req_o,
  input  logic               load_ack_i,
  output logic               store_req_o,
  input  logic               store_ack_i,
  output logic               eng_start_o,
  output logic [1:0]         eng_mode_o,
  output logic               eng_chain_o,
  input  logic               eng_done_i,
  output logic [N_CORES-1:0] evt_o,
  output logic               busy_o,
  output logic               err_o,
  output logic [PEND_W-1:0]  pending_o
);

  ctrl_state_t             state_q, state_d;
  aes_mode_t               mode_q;
  logic [JOB_CORE_MAX-1:0] core_q;
  logic [CNT_W-1:0]        remaining_q;
  logic                    first_q;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    timeout;
  job_t                    head;
  job_t                    push_data;

  assign push_data = '{nb_blocks: JOB_CNT_MAX'(job_nb_blocks_i),
                       mode:      job_mode_i,
                       core:      JOB_CORE_MAX'(job_core_i)};

  aes_job_fifo #(.DEPTH(JOB_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (clear_i),
    .push      (job_valid_i),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending_o)
  );

  assign job_ready_o = !fifo_full;
  assign busy_o      = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    load_req_o  = 1'b0;
    store_req_o = 1'b0;
    eng_start_o = 1'b0;
    eng_mode_o  = 2'b00;
    eng_chain_o = 1'b0;
    evt_o       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = (head.nb_blocks == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_req_o = 1'b1;
        if (load_ack_i) state_d = ST_START;
      end
      ST_START: begin
        eng_start_o = 1'b1;
        eng_mode_o  = mode_q;
        eng_chain_o = is_cbc(mode_q) && !first_q;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done_i)   state_d = ST_STORE;
        else if (timeout) state_d = ST_DONE;
      end
      ST_STORE: begin
        store_req_o = 1'b1;
        if (store_ack_i) state_d = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        for (int i = 0; i < N_CORES; i++) evt_o[i] = (core_q == JOB_CORE_MAX'(i));
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d  = ST_IDLE;
      fifo_pop = 1'b0;
    end
  end

  // Job context latched at pop; chaining only starts after the first stored block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q      <= AES_ECB_ENC;
      core_q      <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
    end else if (clear_i) begin
      mode_q      <= AES_ECB_ENC;
      core_q      <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
    end else if (state_q == ST_IDLE && !fifo_empty) begin
      mode_q      <= head.mode;
      core_q      <= head.core;
      remaining_q <= head.nb_blocks[CNT_W-1:0];
      first_q     <= 1'b1;
    end else if (state_q == ST_STORE && store_ack_i) begin
      first_q     <= 1'b0;
      remaining_q <= remaining_q - 1'b1;
    end
  end

`ifdef AES_JOB_CTRL_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        err_q;

  assign timeout = (state_q == ST_WAIT) && (wait_cnt == 32'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (clear_i) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q != ST_WAIT) wait_cnt <= '0;
      else                    wait_cnt <= wait_cnt + 1'b1;
      if (timeout && !eng_done_i) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_job_ctrl.sv
// Directed self-checking bench for aes_job_ctrl with a small streamer/engine responder.
module tb_aes_job_ctrl;
  import aes_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_nb;
  aes_mode_t   job_mode;
  logic        job_core;
  logic        load_req, load_ack, store_req, store_ack;
  logic        eng_start, eng_chain, eng_done;
  logic [1:0]  eng_mode;
  logic [1:0]  evt;
  logic        busy, err;
  logic [2:0]  pending;

  logic        ack_auto   = 1'b0;
  logic        eng_auto   = 1'b0;
  logic        force_done = 1'b0;
  int          eng_cnt    = 0;

  int          n_load = 0, n_start = 0, n_store = 0, n_evt0 = 0, n_evt1 = 0;
  logic [15:0] chain_hist = '0;
  logic [31:0] mode_hist  = '0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign load_ack  = ack_auto && load_req;
  assign store_ack = ack_auto && store_req;

  aes_job_ctrl #(.N_CORES(2), .JOB_DEPTH(4), .CNT_W(16), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_nb_blocks_i(job_nb),
    .job_mode_i(job_mode), .job_core_i(job_core),
    .load_req_o(load_req), .load_ack_i(load_ack), .store_req_o(store_req), .store_ack_i(store_ack),
    .eng_start_o(eng_start), .eng_mode_o(eng_mode), .eng_chain_o(eng_chain), .eng_done_i(eng_done),
    .evt_o(evt), .busy_o(busy), .err_o(err), .pending_o(pending)
  );

  // Engine answers five cycles after each start when enabled.
  always @(negedge clk) begin
    eng_done = force_done;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
    if (eng_auto && eng_start) eng_cnt = 5;
  end

  always @(negedge clk) begin
    if (load_req && load_ack) n_load++;
    if (store_req && store_ack) n_store++;
    if (eng_start) begin
      n_start++;
      chain_hist = {chain_hist[14:0], eng_chain};
      mode_hist  = {mode_hist[29:0], eng_mode};
    end
    if (evt[0]) n_evt0++;
    if (evt[1]) n_evt1++;
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] nb, input aes_mode_t mode, input logic core);
    job_valid = 1'b1;
    job_nb    = nb;
    job_mode  = mode;
    job_core  = core;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_evt(input string tag, input int bound);
    int i = 0;
    while (evt == 2'b00 && i < bound) begin
      tick();
      i++;
    end
    check_output({tag, "_evt_seen"}, 32'(evt != 2'b00), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int bound);
    int i = 0;
    while (!eng_start && i < bound) begin
      tick();
      i++;
    end
    check_output({tag, "_start_seen"}, 32'(eng_start), 32'd1);
  endtask

  initial begin
    int b_load, b_start, b_store, b_e0, b_e1, i;
    rst = 1'b1; clear = 1'b0; job_valid = 1'b0; job_nb = '0; job_mode = AES_ECB_ENC; job_core = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ready",   32'(job_ready), 32'd1);
    check_output("rst_busy",    32'(busy),      32'd0);
    check_output("rst_pending", 32'(pending),   32'd0);
    check_output("rst_outs",    32'({load_req, store_req, eng_start, eng_chain, eng_mode, evt, err}), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single ECB-enc job, 3 blocks, core 0");
    ack_auto = 1'b1; eng_auto = 1'b1;
    b_load = n_load; b_start = n_start; b_store = n_store; b_e0 = n_evt0; b_e1 = n_evt1;
    apply_stimulus(16'd3, AES_ECB_ENC, 1'b0);
    check_output("ecb_pending_after_push", 32'(pending), 32'd1);
    check_output("ecb_load_req_early",     32'(load_req), 32'd0);
    tick();
    check_output("ecb_load_req_latency",   32'(load_req), 32'd1);
    check_output("ecb_busy",               32'(busy), 32'd1);
    check_output("ecb_pending_popped",     32'(pending), 32'd0);
    wait_evt("ecb", 200);
    check_output("ecb_evt", 32'(evt), 32'h1);
    tick();
    check_output("ecb_evt_pulse", 32'(evt), 32'h0);
    check_output("ecb_idle", 32'(busy), 32'd0);
    check_output("ecb_loads",  32'(n_load - b_load),   32'd3);
    check_output("ecb_starts", 32'(n_start - b_start), 32'd3);
    check_output("ecb_stores", 32'(n_store - b_store), 32'd3);
    check_output("ecb_chain",  32'(chain_hist[2:0]),   32'd0);
    check_output("ecb_evt0",   32'(n_evt0 - b_e0),     32'd1);
    check_output("ecb_evt1",   32'(n_evt1 - b_e1),     32'd0);

    $display("[TB] CBC-enc job, 3 blocks, core 1");
    b_e0 = n_evt0; b_e1 = n_evt1;
    apply_stimulus(16'd3, AES_CBC_ENC, 1'b1);
    wait_evt("cbc", 200);
    check_output("cbc_evt", 32'(evt), 32'h2);
    tick();
    check_output("cbc_chain", 32'(chain_hist[2:0]), 32'b011);
    check_output("cbc_mode",  32'(mode_hist[1:0]),  32'b10);
    check_output("cbc_evt0",  32'(n_evt0 - b_e0),   32'd0);
    check_output("cbc_evt1",  32'(n_evt1 - b_e1),   32'd1);

    $display("[TB] zero-block job");
    b_load = n_load; b_start = n_start;
    apply_stimulus(16'd0, AES_ECB_DEC, 1'b0);
    check_output("zero_evt_early", 32'(evt), 32'h0);
    tick();
    check_output("zero_evt", 32'(evt), 32'h1);
    check_output("zero_load_req", 32'(load_req), 32'd0);
    tick();
    check_output("zero_evt_pulse", 32'(evt), 32'h0);
    check_output("zero_idle", 32'(busy), 32'd0);
    check_output("zero_loads",  32'(n_load - b_load),   32'd0);
    check_output("zero_starts", 32'(n_start - b_start), 32'd0);

    $display("[TB] queue fill while stalled in LOAD");
    ack_auto = 1'b0;
    b_start = n_start; b_e0 = n_evt0; b_e1 = n_evt1;
    apply_stimulus(16'd1, AES_ECB_ENC, 1'b0);
    tick();
    check_output("fill_stalled", 32'(load_req), 32'd1);
    apply_stimulus(16'd1, AES_ECB_DEC, 1'b1);
    apply_stimulus(16'd1, AES_CBC_ENC, 1'b0);
    apply_stimulus(16'd1, AES_CBC_DEC, 1'b1);
    check_output("fill_ready_3", 32'(job_ready), 32'd1);
    apply_stimulus(16'd1, AES_ECB_ENC, 1'b1);
    check_output("fill_ready_4", 32'(job_ready), 32'd0);
    check_output("fill_pending", 32'(pending), 32'd4);
    apply_stimulus(16'd1, AES_CBC_DEC, 1'b1);
    check_output("fill_refused", 32'(pending), 32'd4);
    ack_auto = 1'b1;
    i = 0;
    while (((n_start - b_start) < 5 || busy) && i < 300) begin
      tick();
      i++;
    end
    repeat (10) tick();
    check_output("fill_starts", 32'(n_start - b_start), 32'd5);
    check_output("fill_order",  32'(mode_hist[9:0]), 32'b00_01_10_11_00);
    check_output("fill_evt0",   32'(n_evt0 - b_e0), 32'd2);
    check_output("fill_evt1",   32'(n_evt1 - b_e1), 32'd3);

    $display("[TB] clear during WAIT");
    eng_auto = 1'b0;
    b_start = n_start; b_store = n_store; b_e0 = n_evt0; b_e1 = n_evt1;
    apply_stimulus(16'd2, AES_ECB_ENC, 1'b0);
    apply_stimulus(16'd1, AES_ECB_ENC, 1'b1);
    apply_stimulus(16'd1, AES_ECB_ENC, 1'b0);
    wait_start("clr", 20);
    tick();
    check_output("clr_pending_before", 32'(pending), 32'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("clr_busy",    32'(busy), 32'd0);
    check_output("clr_pending", 32'(pending), 32'd0);
    check_output("clr_ready",   32'(job_ready), 32'd1);
    check_output("clr_outs",    32'({load_req, store_req, eng_start, evt, err}), 32'd0);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    repeat (5) tick();
    check_output("clr_done_ignored", 32'(busy), 32'd0);
    check_output("clr_no_store", 32'(n_store - b_store), 32'd0);
    check_output("clr_no_evt",   32'((n_evt0 - b_e0) + (n_evt1 - b_e1)), 32'd0);
    check_output("clr_one_start", 32'(n_start - b_start), 32'd1);

    $display("[TB] reset mid-job");
    b_e0 = n_evt0; b_e1 = n_evt1;
    apply_stimulus(16'd1, AES_ECB_ENC, 1'b1);
    wait_start("rstjob", 20);
    tick();
    rst = 1'b1;
    #1;
    check_output("rstjob_async_idle", 32'(busy), 32'd0);
    check_output("rstjob_ready", 32'(job_ready), 32'd1);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_output("rstjob_no_evt", 32'((n_evt0 - b_e0) + (n_evt1 - b_e1)), 32'd0);
    check_output("rstjob_err", 32'(err), 32'd0);

`ifdef AES_JOB_CTRL_TIMEOUT_EN
    $display("[TB] engine watchdog");
    eng_auto = 1'b0;
    apply_stimulus(16'd1, AES_ECB_ENC, 1'b1);
    apply_stimulus(16'd1, AES_ECB_DEC, 1'b0);
    wait_start("wdog", 20);
    repeat (16) tick();
    check_output("wdog_err_early", 32'(err), 32'd0);
    tick();
    check_output("wdog_err", 32'(err), 32'd1);
    check_output("wdog_evt", 32'(evt), 32'h2);
    eng_auto = 1'b1;
    wait_evt("wdog_next", 100);
    check_output("wdog_next_evt", 32'(evt), 32'h1);
    check_output("wdog_err_sticky", 32'(err), 32'd1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("wdog_err_cleared", 32'(err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
